ace_snoop_responder: RTL and testbench

- Cache-side end of the ACE snoop interface.
- Accepts snoop requests on AC, looks up the addressed line in the local dcache through a lookup port, and commits the resulting coherence state change through an update port.
- Returns the CR response and, when required, streams the full cache line on CD.
- Sits between the SNOOP_BUS slave port of a cached core and its dcache controller; it answers the snoop traffic that the CCU issues.

---
 rtl/ace_snoop_responder.sv | 172 +++++++++++++++++
 tb/tb_ace_snoop_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ace_snoop_responder.sv
// rtl/ace_snoop_responder.sv - ACE snoop responder: AC accept, dcache lookup/update, CR response and CD line stream.
module ace_snoop_responder #(
    parameter int AxiAddrWidth    = 64,
    parameter int AxiDataWidth    = 64,
    parameter int DcacheLineWidth = 128
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       ac_valid_i,
    output logic                       ac_ready_o,
    input  logic [AxiAddrWidth-1:0]    ac_addr_i,
    input  logic [3:0]                 ac_snoop_i,
    input  logic [2:0]                 ac_prot_i,
    output logic                       cr_valid_o,
    input  logic                       cr_ready_i,
    output logic [4:0]                 cr_resp_o,
    output logic                       cd_valid_o,
    input  logic                       cd_ready_i,
    output logic [AxiDataWidth-1:0]    cd_data_o,
    output logic                       cd_last_o,
    output logic                       lu_req_o,
    input  logic                       lu_gnt_i,
    output logic [AxiAddrWidth-1:0]    lu_addr_o,
    input  logic                       lu_valid_i,
    input  logic                       lu_hit_i,
    input  logic                       lu_dirty_i,
    input  logic                       lu_shared_i,
    input  logic [DcacheLineWidth-1:0] lu_data_i,
    output logic                       upd_req_o,
    input  logic                       upd_gnt_i,
    output logic [AxiAddrWidth-1:0]    upd_addr_o,
    output logic [1:0]                 upd_op_o
);

    localparam int Beats = DcacheLineWidth / AxiDataWidth;
    localparam int BeatW = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WAIT_LU, UPDATE, SEND_CR, SEND_CD
    } state_e;

    state_e                     state_q, state_d;
    logic [AxiAddrWidth-1:0]    addr_q, addr_d;
    logic [3:0]                 snoop_q, snoop_d;
    logic [4:0]                 resp_q, resp_d;
    logic [1:0]                 op_q, op_d;
    logic [DcacheLineWidth-1:0] line_q, line_d;
    logic [BeatW-1:0]           beat_q, beat_d;
    logic [6:0]                 hit_dec;
    logic                       unused_prot;

    assign unused_prot = ^ac_prot_i;

    function automatic logic is_supported(input logic [3:0] sn);
        case (sn)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0111, 4'b1001, 4'b1000, 4'b1101: is_supported = 1'b1;
            default:                           is_supported = 1'b0;
        endcase
    endfunction

    // Returns {op[1:0], resp[4:0]} for a hit; resp = {WasUnique, IsShared, PassDirty, Error, DataTransfer}.
    function automatic logic [6:0] decode_hit(input logic [3:0] sn, input logic d, input logic sh);
        logic [1:0] op;
        logic       dt, is, pd;
        op = 2'd0; dt = 1'b0; is = 1'b0; pd = 1'b0;
        case (sn)
            4'b0000:                   begin dt = 1'b1; is = 1'b1; pd = 1'b0; op = 2'd0; end
            4'b0001, 4'b0010, 4'b0011: begin dt = 1'b1; is = 1'b1; pd = d;    op = 2'd1; end
            4'b0111, 4'b1001:          begin dt = 1'b1; is = 1'b0; pd = d;    op = 2'd2; end
            4'b1000:                   begin dt = d;    is = 1'b1; pd = d;    op = 2'd1; end
            4'b1101:                   begin dt = 1'b0; is = 1'b0; pd = 1'b0; op = 2'd2; end
            default:                   begin dt = 1'b0; is = 1'b0; pd = 1'b0; op = 2'd0; end
        endcase
        decode_hit = {op, ~sh, is, pd, 1'b0, dt};
    endfunction

    assign hit_dec = decode_hit(snoop_q, lu_dirty_i, lu_shared_i);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        snoop_d    = snoop_q;
        resp_d     = resp_q;
        op_d       = op_q;
        line_d     = line_q;
        beat_d     = beat_q;
        lu_req_o   = 1'b0;
        upd_req_o  = 1'b0;
        cr_valid_o = 1'b0;
        cd_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (ac_valid_i) begin
                    addr_d  = ac_addr_i;
                    snoop_d = ac_snoop_i;
                    resp_d  = 5'd0;
                    op_d    = 2'd0;
                    state_d = is_supported(ac_snoop_i) ? LOOKUP : SEND_CR;
                end
            end
            LOOKUP: begin
                lu_req_o = 1'b1;
                if (lu_gnt_i) state_d = WAIT_LU;
            end
            WAIT_LU: begin
                if (lu_valid_i) begin
                    if (lu_hit_i) begin
                        op_d   = hit_dec[6:5];
                        resp_d = hit_dec[4:0];
                        line_d = lu_data_i;
                    end else begin
                        op_d   = 2'd0;
                        resp_d = 5'd0;
                    end
                    state_d = (op_d == 2'd0) ? SEND_CR : UPDATE;
                end
            end
            UPDATE: begin
                upd_req_o = 1'b1;
                if (upd_gnt_i) state_d = SEND_CR;
            end
            SEND_CR: begin
                cr_valid_o = 1'b1;
                if (cr_ready_i) state_d = resp_q[0] ? SEND_CD : IDLE;
            end
            SEND_CD: begin
                cd_valid_o = 1'b1;
                if (cd_ready_i) begin
                    if (beat_q == LastBeat) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BeatW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            snoop_q <= '0;
            resp_q  <= '0;
            op_q    <= '0;
            line_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            snoop_q <= snoop_d;
            resp_q  <= resp_d;
            op_q    <= op_d;
            line_q  <= line_d;
            beat_q  <= beat_d;
        end
    end

    // Gated with rst_i so the port stays low while reset is held, even though IDLE is the reset state.
    assign ac_ready_o = (state_q == IDLE) && !rst_i;
    assign cr_resp_o  = resp_q;
    assign cd_data_o  = line_q[int'(beat_q)*AxiDataWidth +: AxiDataWidth];
    assign cd_last_o  = cd_valid_o && (beat_q == LastBeat);
    assign lu_addr_o  = addr_q;
    assign upd_addr_o = addr_q;
    assign upd_op_o   = op_q;

endmodule

// File: tb/tb_ace_snoop_responder.sv
// tb/tb_ace_snoop_responder.sv - Table-driven bench for ace_snoop_responder.
module tb_ace_snoop_responder;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         ac_valid_i = 1'b0;
    logic         ac_ready_o;
    logic [63:0]  ac_addr_i = '0;
    logic [3:0]   ac_snoop_i = '0;
    logic [2:0]   ac_prot_i = '0;
    logic         cr_valid_o;
    logic         cr_ready_i = 1'b0;
    logic [4:0]   cr_resp_o;
    logic         cd_valid_o;
    logic         cd_ready_i = 1'b0;
    logic [63:0]  cd_data_o;
    logic         cd_last_o;
    logic         lu_req_o;
    logic         lu_gnt_i = 1'b0;
    logic [63:0]  lu_addr_o;
    logic         lu_valid_i = 1'b0;
    logic         lu_hit_i = 1'b0;
    logic         lu_dirty_i = 1'b0;
    logic         lu_shared_i = 1'b0;
    logic [127:0] lu_data_i = '0;
    logic         upd_req_o;
    logic         upd_gnt_i = 1'b0;
    logic [63:0]  upd_addr_o;
    logic [1:0]   upd_op_o;

    ace_snoop_responder dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
        .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i),
        .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
        .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o), .cd_last_o(cd_last_o),
        .lu_req_o(lu_req_o), .lu_gnt_i(lu_gnt_i), .lu_addr_o(lu_addr_o), .lu_valid_i(lu_valid_i),
        .lu_hit_i(lu_hit_i), .lu_dirty_i(lu_dirty_i), .lu_shared_i(lu_shared_i), .lu_data_i(lu_data_i),
        .upd_req_o(upd_req_o), .upd_gnt_i(upd_gnt_i), .upd_addr_o(upd_addr_o), .upd_op_o(upd_op_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]   sn;
        logic [63:0]  addr;
        logic         hit;
        logic         dirty;
        logic         shared;
        logic [127:0] line;
        int           stall;
        logic         early;
        logic [4:0]   resp;
        logic [1:0]   op;
        int           beats;
        logic         lu;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    vec_t vecs[12];

    localparam logic [127:0] LINE_A = 128'hAAAA_AAAA_AAAA_AAAA_5555_5555_5555_5555;
    localparam logic [127:0] LINE_B = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] or_outputs();
        return {63'd0, |{ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
                         lu_req_o, lu_addr_o, upd_req_o, upd_addr_o, upd_op_o}};
    endfunction

    task automatic run(input vec_t v, input logic abort);
        int          saw_lu, saw_upd, saw_cr, beats, stall, cyc;
        logic        pend, done;
        logic [4:0]  resp;
        logic [1:0]  op;
        logic [63:0] held;
        saw_lu = 0; saw_upd = 0; saw_cr = 0; beats = 0; stall = v.stall;
        pend = 1'b0; done = 1'b0; resp = '0; op = '0; held = '0;
        @(posedge clk_i); #1;
        chk("ac_ready_idle", {63'd0, ac_ready_o}, 64'd1);
        ac_valid_i = 1'b1; ac_addr_i = v.addr; ac_snoop_i = v.sn;
        @(posedge clk_i); #1;
        ac_valid_i = 1'b0;
        for (cyc = 0; cyc < 60; cyc++) begin
            lu_gnt_i = 0; lu_valid_i = 0; lu_hit_i = 0; lu_dirty_i = 0; lu_shared_i = 0;
            lu_data_i = '0; upd_gnt_i = 0; cr_ready_i = 0; cd_ready_i = 0;
            if (ac_ready_o && saw_cr > 0 && beats == v.beats) begin
                done = 1'b1;
                break;
            end
            if (pend) begin
                lu_valid_i = 1; lu_hit_i = v.hit; lu_dirty_i = v.dirty;
                lu_shared_i = v.shared; lu_data_i = v.line; pend = 1'b0;
            end
            if (lu_req_o) begin
                chk("lu_addr", lu_addr_o, v.addr);
                lu_gnt_i = 1; pend = 1'b1; saw_lu++;
                if (v.early) begin
                    lu_valid_i = 1; lu_hit_i = 1; lu_dirty_i = 1; lu_data_i = ~v.line;
                end
            end
            if (upd_req_o) begin
                chk("upd_addr", upd_addr_o, v.addr);
                upd_gnt_i = 1; op = upd_op_o; saw_upd++;
            end
            if (cr_valid_o) begin
                cr_ready_i = 1; resp = cr_resp_o; saw_cr++;
            end
            if (cd_valid_o) begin
                if (abort) begin
                    rst_i = 1'b1;
                    #1;
                    chk("outputs_in_reset", or_outputs(), 64'd0);
                    repeat (2) @(posedge clk_i);
                    #1;
                    rst_i = 1'b0;
                    repeat (3) begin
                        @(posedge clk_i); #1;
                        chk("no_resp_after_abort", {62'd0, cr_valid_o, cd_valid_o}, 64'd0);
                    end
                    chk("ac_ready_after_abort", {63'd0, ac_ready_o}, 64'd1);
                    return;
                end
                chk("cd_data", cd_data_o, v.line[beats*64 +: 64]);
                chk("cd_last", {63'd0, cd_last_o}, {63'd0, beats == v.beats - 1});
                if (stall > 0) begin
                    if (stall < v.stall) chk("cd_stall_stable", cd_data_o, held);
                    held = cd_data_o;
                    stall--;
                end else begin
                    cd_ready_i = 1; beats++;
                end
            end
            @(posedge clk_i); #1;
        end
        if (!done) chk("timeout", 64'd0, 64'd1);
        chk("cr_count", saw_cr, 1);
        chk("cr_resp", {59'd0, resp}, {59'd0, v.resp});
        chk("lu_issued", {63'd0, saw_lu > 0}, {63'd0, v.lu});
        chk("upd_count", saw_upd, (v.op != 2'd0) ? 1 : 0);
        chk("upd_op", {62'd0, op}, {62'd0, v.op});
        chk("cd_beats", beats, v.beats);
    endtask

    initial begin
        //          sn     addr        hit dirty shared line    stall early resp      op    beats lu
        vecs[0]  = '{4'h1, 64'h1000,   1, 1, 0, LINE_A, 0, 0, 5'b11101, 2'd1, 2, 1};
        vecs[1]  = '{4'h7, 64'h2040,   1, 0, 1, LINE_A, 4, 0, 5'b00001, 2'd2, 2, 1};
        vecs[2]  = '{4'h8, 64'h3080,   1, 0, 0, LINE_B, 0, 0, 5'b11000, 2'd1, 0, 1};
        vecs[3]  = '{4'h1, 64'h40C0,   0, 0, 0, LINE_B, 0, 1, 5'b00000, 2'd0, 0, 1};
        vecs[4]  = '{4'h5, 64'h5000,   1, 1, 0, LINE_A, 0, 0, 5'b00000, 2'd0, 0, 0};
        vecs[5]  = '{4'h0, 64'h6040,   1, 0, 1, LINE_B, 0, 0, 5'b01001, 2'd0, 2, 1};
        vecs[6]  = '{4'hD, 64'h7080,   1, 1, 0, LINE_A, 0, 0, 5'b10000, 2'd2, 0, 1};
        vecs[7]  = '{4'h9, 64'h80C0,   1, 1, 1, LINE_B, 0, 0, 5'b00101, 2'd2, 2, 1};
        vecs[8]  = '{4'h8, 64'h9000,   1, 1, 1, LINE_A, 0, 0, 5'b01101, 2'd1, 2, 1};
        vecs[9]  = '{4'h3, 64'hA040,   1, 0, 0, LINE_B, 0, 0, 5'b11001, 2'd1, 2, 1};
        vecs[10] = '{4'h7, 64'hB080,   0, 1, 1, LINE_A, 0, 1, 5'b00000, 2'd0, 0, 1};
        vecs[11] = '{4'hF, 64'hC0C0,   1, 1, 1, LINE_A, 0, 0, 5'b00000, 2'd0, 0, 0};

        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_outputs", or_outputs(), 64'd0);
        rst_i = 1'b0;
        #1;
        chk("ac_ready_after_reset", {63'd0, ac_ready_o}, 64'd1);

        foreach (vecs[i]) run(vecs[i], 1'b0);

        run(vecs[0], 1'b1);
        run(vecs[0], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, required completion");
        $fatal(1);
    end

endmodule
